// File: rtl/set_bit_enumerator.sv
// set_bit_enumerator: accepts one WIDTH-bit word over valid/ready, streams the
// index of each set bit (one per beat), then pulses done with the bit count.
// Optional build macro: SET_BIT_ENUMERATOR_MSB_FIRST_EN -- when defined, indices
// are emitted highest first instead of lowest first.
module set_bit_enumerator #(
  parameter  int WIDTH = 8,
  localparam int IW    = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IW-1:0]    out_idx,
  output logic             out_last,
  output logic             done,
  output logic [IW:0]      count
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] shadow, shadow_nxt;
  logic [IW:0]      count_nxt;
  logic             done_nxt;
  logic [IW-1:0]    pick;
  logic             single;
  logic             accept, fire;

  // Priority pick over the remaining bits; the loop direction decides which
  // end wins (the last match in loop order overrides earlier ones).
  always_comb begin
    pick = '0;
`ifdef SET_BIT_ENUMERATOR_MSB_FIRST_EN
    for (int i = 0; i < WIDTH; i++)
      if (shadow[i]) pick = IW'(i);
`else
    for (int i = WIDTH - 1; i >= 0; i--)
      if (shadow[i]) pick = IW'(i);
`endif
  end

  // Exactly one bit left: clearing the lowest set bit leaves nothing.
  assign single = (|shadow) && ((shadow & (shadow - WIDTH'(1))) == '0);

  // Handshake outputs depend only on state, so out_ready never reaches them.
  assign in_ready  = (state == IDLE);
  assign out_valid = (state == EMIT);
  assign out_idx   = out_valid ? pick : '0;
  assign out_last  = out_valid && single;

  assign accept = in_valid && in_ready;
  assign fire   = out_valid && out_ready;

  // Next-state logic: word capture in IDLE, one bit retired per beat in EMIT.
  always_comb begin
    state_nxt  = state;
    shadow_nxt = shadow;
    count_nxt  = count;
    done_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        // count is only meaningful through the done cycle; clear it after.
        count_nxt = '0;
        if (accept) begin
          shadow_nxt = in_data;
          if (in_data != '0) state_nxt = EMIT;
          else               done_nxt  = 1'b1;
        end
      end
      EMIT: begin
        if (fire) begin
          shadow_nxt = shadow & ~(WIDTH'(1) << pick);
          count_nxt  = count + 1'b1;
          if (single) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State registers with synchronous active-low reset; reset mid-word drops
  // the remaining bits without a done pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      shadow <= '0;
      count  <= '0;
      done   <= 1'b0;
    end else begin
      state  <= state_nxt;
      shadow <= shadow_nxt;
      count  <= count_nxt;
      done   <= done_nxt;
    end
  end

endmodule

// File: tb/tb_set_bit_enumerator.sv
// Self-checking bench for set_bit_enumerator (WIDTH=8). Expected index
// streams come from a bit-scan model; define SET_BIT_ENUMERATOR_MSB_FIRST_EN
// for both bench and RTL to check the descending build.
module tb_set_bit_enumerator;
  localparam int W  = 8;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_idx;
  logic          out_last;
  logic          done;
  logic [IW:0]   count;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  set_bit_enumerator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // Reference: list of set-bit positions in emission order.
  function automatic void model(input logic [W-1:0] w);
    exp_q.delete();
`ifdef SET_BIT_ENUMERATOR_MSB_FIRST_EN
    for (int i = W - 1; i >= 0; i--) if (w[i]) exp_q.push_back(i);
`else
    for (int i = 0; i < W; i++) if (w[i]) exp_q.push_back(i);
`endif
  endfunction

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept_word(input logic [W-1:0] w);
    in_valid = 1'b1;
    in_data  = w;
    tick();
    in_valid = 1'b0;
    in_data  = $urandom;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b1; in_data = 8'hFF; out_ready = 1'b1;
    tick(); tick();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_idx !== '0 ||
        out_last !== 1'b0 || count !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL reset: rdy=%b vld=%b idx=%0d last=%b cnt=%0d done=%b, want 1 0 0 0 0 0",
               in_ready, out_valid, out_idx, out_last, count, done);
    end
    in_valid = 1'b0;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_pattern(input logic [W-1:0] w);
    int n;
    model(w);
    n = exp_q.size();
    out_ready = 1'b1;
    accept_word(w);
    for (int k = 0; k < n; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== IW'(exp_q[k]) ||
          out_last !== (k == n - 1) || count !== (IW + 1)'(k) || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL pattern beat%0d: vld=%b idx=%0d last=%b cnt=%0d rdy=%b, want 1 %0d %0d %0d 0",
                 k, out_valid, out_idx, out_last, count, in_ready, exp_q[k], (k == n - 1), k);
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || count !== (IW + 1)'(n) || out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL pattern done: done=%b cnt=%0d vld=%b rdy=%b, want 1 %0d 0 1",
               done, count, out_valid, in_ready, n);
    end
    tick();
    checks++;
    if (done !== 1'b0 || count !== '0) begin
      errors++;
      $display("FAIL pattern after: done=%b cnt=%0d, want 0 0", done, count);
    end
  endtask

  task automatic test_zero();
    out_ready = 1'b1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero ready before: got %b want 1", in_ready);
    end
    accept_word('0);
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b1 || count !== '0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero done: vld=%b done=%b cnt=%0d rdy=%b, want 0 1 0 1",
               out_valid, done, count, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || done !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL zero after: vld=%b done=%b rdy=%b, want 0 0 1", out_valid, done, in_ready);
    end
  endtask

  task automatic test_backpressure();
    model(8'b0000_0110);
    out_ready = 1'b0;
    accept_word(8'b0000_0110);
    for (int c = 0; c < 4; c++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== IW'(exp_q[0]) || out_last !== 1'b0 ||
          count !== '0 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall cyc%0d: vld=%b idx=%0d last=%b cnt=%0d rdy=%b, want 1 %0d 0 0 0",
                 c, out_valid, out_idx, out_last, count, in_ready, exp_q[0]);
      end
      if (c == 3) out_ready = 1'b1;
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || out_idx !== IW'(exp_q[1]) || out_last !== 1'b1 ||
        count !== 4'd1 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL stall second: vld=%b idx=%0d last=%b cnt=%0d rdy=%b, want 1 %0d 1 1 0",
               out_valid, out_idx, out_last, count, in_ready, exp_q[1]);
    end
    tick();
    checks++;
    if (done !== 1'b1 || count !== 4'd2 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall done: done=%b cnt=%0d rdy=%b, want 1 2 1", done, count, in_ready);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    model(8'hFF);
    out_ready = 1'b1;
    accept_word(8'hFF);
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== IW'(exp_q[k]) || out_last !== (k == 7)) begin
        errors++;
        $display("FAIL b2b beat%0d: vld=%b idx=%0d last=%b, want 1 %0d %0d",
                 k, out_valid, out_idx, out_last, exp_q[k], (k == 7));
      end
      tick();
    end
    checks++;
    if (done !== 1'b1 || count !== 4'b1000 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b done: done=%b cnt=%b rdy=%b, want 1 1000 1", done, count, in_ready);
    end
    accept_word(8'h80);
    checks++;
    if (out_valid !== 1'b1 || out_idx !== 3'd7 || out_last !== 1'b1 || count !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b second: vld=%b idx=%0d last=%b cnt=%0d done=%b, want 1 7 1 0 0",
               out_valid, out_idx, out_last, count, done);
    end
    tick();
    checks++;
    if (done !== 1'b1 || count !== 4'd1) begin
      errors++;
      $display("FAIL b2b second done: done=%b cnt=%0d, want 1 1", done, count);
    end
    tick();
  endtask

  task automatic test_reset_mid_emit();
    model(8'b1111_0000);
    out_ready = 1'b1;
    accept_word(8'b1111_0000);
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (out_valid !== 1'b1 || out_idx !== IW'(exp_q[k])) begin
        errors++;
        $display("FAIL rstmid beat%0d: vld=%b idx=%0d, want 1 %0d", k, out_valid, out_idx, exp_q[k]);
      end
      tick();
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== '0 || done !== 1'b0) begin
      errors++;
      $display("FAIL rstmid after: vld=%b rdy=%b cnt=%0d done=%b, want 0 1 0 0",
               out_valid, in_ready, count, done);
    end
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0 || done !== 1'b0) begin
        errors++;
        $display("FAIL rstmid quiet%0d: vld=%b done=%b, want 0 0", c, out_valid, done);
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] w;
    int n, k, guard;
    logic was_vld;
    for (int t = 0; t < 40; t++) begin
      w = $urandom;
      if (t % 4 == 1) w = w & $urandom;
      if (t % 9 == 3) w = '0;
      model(w);
      n = exp_q.size();
      accept_word(w);
      k = 0;
      guard = 0;
      while (k < n && guard < 200) begin
        checks++;
        if (out_valid !== 1'b1 || out_idx !== IW'(exp_q[k]) || out_last !== (k == n - 1) ||
            count !== (IW + 1)'(k) || in_ready !== 1'b0) begin
          errors++;
          $display("FAIL random w=%h beat%0d: vld=%b idx=%0d last=%b cnt=%0d rdy=%b, want 1 %0d %0d %0d 0",
                   w, k, out_valid, out_idx, out_last, count, in_ready, exp_q[k], (k == n - 1), k);
        end
        was_vld   = out_valid;
        out_ready = ($urandom_range(0, 99) < 65);
        in_valid  = $urandom;
        in_data   = $urandom;
        tick();
        if (was_vld && out_ready) k++;
        guard++;
      end
      in_valid = 1'b0;
      if (guard >= 200) begin
        errors++;
        $display("FAIL random timeout w=%h: beats %0d of %0d", w, k, n);
      end
      checks++;
      if (done !== 1'b1 || count !== (IW + 1)'(n) || out_valid !== 1'b0) begin
        errors++;
        $display("FAIL random done w=%h: done=%b cnt=%0d vld=%b, want 1 %0d 0", w, done, count, out_valid, n);
      end
      for (int g = $urandom_range(0, 2); g >= 0; g--) tick();
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    test_reset();
    test_pattern(8'b1010_0101);
    test_zero();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_emit();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Absolute time bound so a stuck DUT cannot hang the run.
  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
